// File: rtl/stego_pkg.sv
// stego_pkg: shared widths and FSM encoding for the stego frame pipeline
package stego_pkg;
  localparam int BPS_DEF = 16;
  localparam int FRAME_SIZE_DEF = 8;
  typedef enum logic [1:0] {
    S_FILL     = 2'b00,
    S_WAIT_MSG = 2'b01,
    S_ISSUE    = 2'b10,
    S_BUSY     = 2'b11
  } state_t;
  function automatic int frame_w(input int frame_size, input int bps);
    return frame_size * bps;
  endfunction
endpackage

// File: rtl/frame_assembler.sv
// frame_assembler: packs FRAME_SIZE samples plus one message chunk into a frame for the LSB embedder
module frame_assembler
  import stego_pkg::*;
#(
  parameter int BPS        = BPS_DEF,
  parameter int FRAME_SIZE = FRAME_SIZE_DEF
) (
  input  logic                              in_clk,
  input  logic                              in_rst_n,
  input  logic [BPS-1:0]                    in_sample,
  input  logic                              in_sample_valid,
  output logic                              out_sample_ready,
  input  logic [FRAME_SIZE-1:0]             in_message,
  input  logic                              in_message_valid,
  output logic                              out_message_ready,
  output logic [frame_w(FRAME_SIZE,BPS)-1:0] out_frame,
  output logic [FRAME_SIZE-1:0]             out_message,
  output logic                              out_enable,
  input  logic                              in_done,
  output logic [15:0]                       out_frame_cnt
);
  localparam int CW = $clog2(FRAME_SIZE);
  localparam logic [CW-1:0] LAST = CW'(FRAME_SIZE - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic msg_full, msg_full_n, s_acc, m_acc;
  assign s_acc = in_sample_valid & out_sample_ready;
  assign m_acc = in_message_valid & out_message_ready;
  always_comb begin
    state_n = state;
    msg_full_n = msg_full | m_acc;
    case (state)
      S_FILL:     state_n = (s_acc && cnt == LAST) ? (msg_full_n ? S_ISSUE : S_WAIT_MSG) : S_FILL;
      S_WAIT_MSG: state_n = m_acc ? S_ISSUE : S_WAIT_MSG;
      S_ISSUE:    state_n = S_BUSY;
      S_BUSY: begin
        state_n = in_done ? S_FILL : S_BUSY;
        msg_full_n = msg_full & ~in_done;
      end
    endcase
  end
  // ready/enable are registered from the next state so they track the FSM without a bubble
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      state <= S_FILL;
      cnt <= '0;
      msg_full <= 1'b0;
      out_frame <= '0;
      out_message <= '0;
      out_frame_cnt <= '0;
      out_sample_ready <= 1'b0;
      out_message_ready <= 1'b0;
      out_enable <= 1'b0;
    end else begin
      state <= state_n;
      msg_full <= msg_full_n;
      out_sample_ready <= state_n == S_FILL;
      out_message_ready <= !msg_full_n && (state_n == S_FILL || state_n == S_WAIT_MSG);
      out_enable <= state_n == S_ISSUE;
      if (s_acc) begin
        out_frame[cnt*BPS +: BPS] <= in_sample;
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
      if (m_acc) out_message <= in_message;
      if (state == S_BUSY && in_done) out_frame_cnt <= out_frame_cnt + 16'd1;
    end
endmodule

// File: tb/tb_frame_assembler.sv
// tb_frame_assembler: scoreboard bench with an embedder model answering each enable with a done pulse
module tb_frame_assembler;
  logic in_clk, in_rst_n;
  logic [15:0] in_sample;
  logic in_sample_valid, out_sample_ready;
  logic [7:0] in_message, out_message;
  logic in_message_valid, out_message_ready;
  logic [127:0] out_frame;
  logic out_enable, in_done, emb_done, stray_done;
  logic [15:0] out_frame_cnt;
  typedef struct { logic [127:0] frame; logic [7:0] msg; logic [15:0] cnt; } exp_t;
  exp_t sb[$];
  int en_q[$];
  int s_acc[16];
  int m_acc, m_acc_a;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  assign in_done = emb_done | stray_done;

  frame_assembler dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n),
    .in_sample(in_sample), .in_sample_valid(in_sample_valid), .out_sample_ready(out_sample_ready),
    .in_message(in_message), .in_message_valid(in_message_valid), .out_message_ready(out_message_ready),
    .out_frame(out_frame), .out_message(out_message), .out_enable(out_enable),
    .in_done(in_done), .out_frame_cnt(out_frame_cnt)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;
  always @(posedge in_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur", nm);
  endtask

  function automatic logic [127:0] mk_frame(input logic [15:0] b);
    logic [127:0] f;
    for (int k = 0; k < 8; k++) f[k*16 +: 16] = b + 16'(k);
    return f;
  endfunction

  task automatic send_samples(input logic [15:0] base, input int n);
    int t;
    bit acc;
    for (int i = 0; i < n; i++) begin
      t = 0;
      acc = 0;
      in_sample = base + 16'(i);
      in_sample_valid = 1'b1;
      while (!acc) begin
        @(negedge in_clk);
        acc = out_sample_ready;
        if (acc && i < 16) s_acc[i] = cyc;
        @(posedge in_clk); #1;
        if (++t > 100) begin fail("sample_accept_timeout"); acc = 1; end
      end
    end
    in_sample_valid = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] m);
    int t;
    bit acc;
    t = 0;
    acc = 0;
    in_message = m;
    in_message_valid = 1'b1;
    while (!acc) begin
      @(negedge in_clk);
      acc = out_message_ready;
      if (acc) m_acc = cyc;
      @(posedge in_clk); #1;
      if (++t > 100) begin fail("msg_accept_timeout"); acc = 1; end
    end
    in_message_valid = 1'b0;
  endtask

  task automatic wait_cnt(input logic [15:0] exp, input string nm);
    int t;
    t = 0;
    do begin @(negedge in_clk); t++; end while (out_frame_cnt !== exp && t < 60);
    chk(nm, out_frame_cnt, exp);
    @(posedge in_clk); #1;
  endtask

  // embedder model: done pulse in the third cycle after the enable cycle
  initial begin
    emb_done = 1'b0;
    forever begin
      @(negedge in_clk);
      if (out_enable) begin
        repeat (3) @(posedge in_clk);
        #1 emb_done = 1'b1;
        @(posedge in_clk);
        #1 emb_done = 1'b0;
      end
    end
  end

  // monitor: pops the scoreboard on each enable and checks hold-stability at done
  initial begin
    exp_t e;
    bit prev_en, held;
    logic [127:0] hf;
    logic [7:0] hm;
    prev_en = 0;
    held = 0;
    forever begin
      @(negedge in_clk);
      if (in_rst_n) begin
        if (out_enable) begin
          chk("enable_width", 128'(prev_en), 0);
          en_q.push_back(cyc);
          if (sb.size() == 0) fail("expected_frame_for_enable");
          else begin
            e = sb.pop_front();
            chk("frame", out_frame, e.frame);
            chk("message", 128'(out_message), 128'(e.msg));
            chk("cnt_at_issue", 128'(out_frame_cnt), 128'(e.cnt));
            held = 1;
            hf = out_frame;
            hm = out_message;
          end
        end
        if (in_done && held) begin
          chk("frame_stable", out_frame, hf);
          chk("msg_stable", 128'(out_message), 128'(hm));
          held = 0;
        end
      end
      prev_en = out_enable;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_rst_n = 1'b0;
    in_sample = '0;
    in_sample_valid = 1'b0;
    in_message = '0;
    in_message_valid = 1'b0;
    stray_done = 1'b0;
    repeat (2) @(posedge in_clk);
    @(negedge in_clk);
    chk("rst_sready", 128'(out_sample_ready), 0);
    chk("rst_mready", 128'(out_message_ready), 0);
    chk("rst_enable", 128'(out_enable), 0);
    chk("rst_frame", out_frame, 0);
    chk("rst_message", 128'(out_message), 0);
    chk("rst_cnt", 128'(out_frame_cnt), 0);
    @(posedge in_clk); #1 in_rst_n = 1'b1;
    @(negedge in_clk);
    chk("release_sready_low", 128'(out_sample_ready), 0);
    @(posedge in_clk); #1;
    @(negedge in_clk);
    chk("release_sready_high", 128'(out_sample_ready), 1);
    chk("release_mready_high", 128'(out_message_ready), 1);
    @(posedge in_clk); #1;

    // chunk first, then samples
    sb.push_back('{128'h1007_1006_1005_1004_1003_1002_1001_1000, 8'hA5, 16'd0});
    send_msg(8'hA5);
    send_samples(16'h1000, 8);
    wait_cnt(16'd1, "t1_cnt");
    chk("t1_enable_latency", 128'(en_q.size() > 0 ? en_q[0] : -1), 128'(s_acc[7] + 1));
    chk("t1_enable_count", 128'(en_q.size()), 1);

    // chunk arrives late
    sb.push_back('{mk_frame(16'h2000), 8'h3C, 16'd1});
    send_samples(16'h2000, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge in_clk);
      chk("t2_sready_wait", 128'(out_sample_ready), 0);
      @(posedge in_clk); #1;
    end
    send_msg(8'h3C);
    wait_cnt(16'd2, "t2_cnt");
    chk("t2_enable_after_chunk", 128'(en_q.size() > 1 ? en_q[1] : -1), 128'(m_acc + 1));

    // simultaneous last-sample/chunk accept, then back-pressured back-to-back frame
    sb.push_back('{mk_frame(16'h3000), 8'h5A, 16'd2});
    sb.push_back('{mk_frame(16'h3008), 8'hC3, 16'd3});
    fork
      send_samples(16'h3000, 16);
      begin
        repeat (7) begin @(posedge in_clk); #1; end
        send_msg(8'h5A);
        m_acc_a = m_acc;
        send_msg(8'hC3);
      end
    join
    wait_cnt(16'd4, "t3_cnt");
    chk("t3_simul_accept", 128'(m_acc_a), 128'(s_acc[7]));
    chk("t3_enable_latency", 128'(en_q.size() > 2 ? en_q[2] : -1), 128'(s_acc[7] + 1));
    chk("t4_slot0_after_done", 128'(s_acc[8]), 128'(en_q.size() > 2 ? en_q[2] + 4 : -1));
    chk("t4_period", 128'(en_q.size() > 3 ? en_q[3] - en_q[2] : -1), 12);

    // stray done while filling, then reset mid-fill
    send_msg(8'h77);
    send_samples(16'h4000, 3);
    stray_done = 1'b1;
    @(posedge in_clk); #1 stray_done = 1'b0;
    @(negedge in_clk);
    chk("stray_cnt", 128'(out_frame_cnt), 4);
    chk("stray_mready", 128'(out_message_ready), 0);
    chk("stray_sready", 128'(out_sample_ready), 1);
    chk("stray_no_enable", 128'(en_q.size()), 4);
    in_rst_n = 1'b0;
    #1;
    chk("midrst_sready", 128'(out_sample_ready), 0);
    chk("midrst_mready", 128'(out_message_ready), 0);
    chk("midrst_frame", out_frame, 0);
    chk("midrst_message", 128'(out_message), 0);
    chk("midrst_cnt", 128'(out_frame_cnt), 0);
    @(posedge in_clk); #1 in_rst_n = 1'b1;
    @(posedge in_clk); #1;
    sb.push_back('{mk_frame(16'h5000), 8'h96, 16'd0});
    fork
      send_msg(8'h96);
      send_samples(16'h5000, 8);
    join
    wait_cnt(16'd1, "post_reset_cnt");

    // counter wrap from a preloaded 0xFFFF
    force dut.out_frame_cnt = 16'hFFFF;
    @(posedge in_clk); #1 release dut.out_frame_cnt;
    @(negedge in_clk);
    chk("preload_cnt", 128'(out_frame_cnt), 128'(16'hFFFF));
    @(posedge in_clk); #1;
    sb.push_back('{mk_frame(16'h6000), 8'h0F, 16'hFFFF});
    fork
      send_msg(8'h0F);
      send_samples(16'h6000, 8);
    join
    wait_cnt(16'd0, "wrap_cnt");
    chk("sb_drained", 128'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_assembler.md
# frame_assembler

Upstream feeder for the LSB embedder (`bit_changer_seq`). It collects audio samples one at a time over a valid/ready stream and packs FRAME_SIZE of them into a flat frame. It also captures one FRAME_SIZE-bit message chunk per frame, then issues a one-cycle enable to the embedder. Frame and message are held stable until the embedder's done pulse returns, after which the next frame is collected.

## Interface
- BPS, 16, bits per sample; must match the embedder.
- FRAME_SIZE, 8, samples per frame, which is also message bits per frame; ≥2.
- in_clk  input  1  clock; all logic on the rising edge.
- in_rst_n  input  1  reset, asynchronous, active-low.
- in_sample  input  BPS  sample data.
- in_sample_valid  input  1  sample offered.
- out_sample_ready  output  1  sample accepted when this and valid are both high at the clock edge.
- in_message  input  FRAME_SIZE  message chunk; bit k goes to sample k.
- in_message_valid  input  1  chunk offered.
- out_message_ready  output  1  chunk accepted when this and valid are both high at the clock edge.
- out_frame  output  FRAME_SIZE*BPS  packed frame to the embedder's in_frame; sample k occupies bits [k*BPS +: BPS].
- out_message  output  FRAME_SIZE  captured chunk to the embedder's in_message.
- out_enable  output  1  one-cycle start pulse to the embedder's in_enable.
- in_done  input  1  embedder's out_ready pulse.
- out_frame_cnt  output  16  number of completed frames (done pulses received); wraps at 0xFFFF→0.

## Operation
- Registers:
  - state;
  - sample counter, width $clog2(FRAME_SIZE);
  - frame register;
  - message register plus msg_full flag;
  - frame counter.
- States:
  - S_FILL: out_sample_ready=1. Each accepted sample is written at slot cnt, then cnt increments. The accept at cnt==FRAME_SIZE-1 clears cnt and goes to S_WAIT_MSG, or directly to S_ISSUE if msg_full is set or a chunk is accepted in the same cycle.
  - S_WAIT_MSG: out_sample_ready=0. Goes to S_ISSUE on a chunk accept.
  - S_ISSUE: out_enable=1 for exactly this cycle, then S_BUSY.
  - S_BUSY: waits for in_done=1. On that cycle:
    - clear msg_full;
    - increment out_frame_cnt;
    - go to S_FILL.
- Message capture is independent of sample filling. out_message_ready = !msg_full in S_FILL and S_WAIT_MSG, and 0 in S_ISSUE and S_BUSY. A chunk may therefore arrive before, during, or after the samples.
- out_frame and out_message are driven directly from the registers. They are constant from S_ISSUE entry until the in_done cycle, because the embedder reads them combinationally one cycle after enable.
- The frame register is not cleared between frames; every slot is overwritten before the next issue.
- in_done outside S_BUSY is ignored: no state change, no count.
- in_sample_valid held high in S_WAIT_MSG, S_ISSUE or S_BUSY: nothing is consumed (ready low).

## Timing
- Reset (async assert, sync release): out_sample_ready=0, out_message_ready=0, out_enable=0, out_frame=0, out_message=0, out_frame_cnt=0, state S_FILL, cnt=0, msg_full=0.
- Both ready outputs are registered. They rise on the first clock edge after in_rst_n goes high.
- out_sample_ready drops in the cycle after the last-sample accept, so no extra sample is taken.
- Last sample accepted at edge T with message already held: out_enable high in cycle T+1.
- Issue latency with `bit_changer_seq`:
  - enable in cycle E;
  - embedder output valid from E+2;
  - in_done in cycle E+3;
  - out_sample_ready high from E+4.
- Fastest frame period: FRAME_SIZE + 4 cycles.
- Simultaneous last-sample accept and chunk accept: go straight to S_ISSUE.
- Reset asserted mid-frame or in S_BUSY: everything returns to reset values immediately and the partial frame is discarded. The embedder is reset separately.

## Structure
- Shared package `stego_pkg`:
  - BPS and FRAME_SIZE defaults;
  - state encodings (S_FILL=2'b00, S_WAIT_MSG=2'b01, S_ISSUE=2'b10, S_BUSY=2'b11);
  - frame-width helper FRAME_SIZE*BPS.
- No sub-module. Single always block for state and datapath, plus the async-reset sensitivity.

## Test plan
- Reset then fill: samples 0x1000..0x1007 with chunk 8'hA5 offered first. Required: out_frame = {0x1007,…,0x1000}, out_message=8'hA5, one out_enable pulse; after the embedder's in_done, out_frame_cnt=1.
- Chunk late: 8 samples, chunk 8'h3C given 5 cycles later. Required: out_sample_ready=0 while waiting; out_enable exactly 1 cycle after the chunk accept.
- Back-pressure: in_sample_valid held high through S_ISSUE/S_BUSY with the embedder attached. Required: sample 9 is accepted only after in_done and lands in slot 0; back-to-back period is 12 cycles.
- Stray in_done pulse in S_FILL: no state change; out_frame_cnt unchanged.
- Reset mid-fill after 3 samples: all outputs 0. The next 8 samples form a clean frame in which slot 0 holds the first post-reset sample.
- Counter wrap: preload or run 65536 frames. Required: out_frame_cnt wraps 0xFFFF→0.
